instr_sweeper: RTL
==================

INSTR_SWEEPER -- requirements
Module: instr_sweeper

Interface
REQ-001 Parameter SETTLE, default 2, is the number of extra cycles each operand vector is held before the response is captured; legal range 0..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-005 op  input  8  instruction code to sweep; captured on the accepted start.
REQ-006 instruction  output  8  instruction driven to the ALU under test.
REQ-007 data0  output  2  first operand driven to the ALU.
REQ-008 data1  output  2  second operand driven to the ALU.
REQ-009 ok  input  1  ALU "instruction valid" response.
REQ-010 ovf  input  1  ALU overflow response.
REQ-011 instr_out  input  8  ALU instruction echo.
REQ-012 out0  input  2  ALU result low part; out1  input  2  ALU result high part.
REQ-013 busy  output  1  high from the accepted start until done is asserted.
REQ-014 done  output  1  one-cycle pulse marking sweep completion.
REQ-015 ovf_count  output  5  number of captured vectors with ovf=1.
REQ-016 err_count  output  5  number of captured vectors failing the echo check.
REQ-017 signature  output  4  running XOR of {out1,out0} over captured vectors.

Function
REQ-018 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-019 IDLE: start=1 -> DRIVE; latch op into instruction; data0=0, data1=0; clear ovf_count, err_count, signature; busy=1.
REQ-020 DRIVE: hold the vector for SETTLE cycles (internal settle counter), then -> SAMPLE; SETTLE=0 -> SAMPLE on the next edge.
REQ-021 SAMPLE: on its single edge, capture ok, ovf, instr_out, out0, out1 and update the counters and signature.
REQ-022 Sweep order: data1 inner loop 0..3, data0 outer loop 0..3, 16 vectors total; the next vector is driven on the SAMPLE edge.
REQ-023 After vector (data0=3, data1=3) is sampled -> DONE; DONE asserts done=1 and busy=0 for one cycle, then -> IDLE.
REQ-024 Start-to-done latency SHALL be exactly 16*(SETTLE+1)+1 cycles from the edge accepting start to the edge asserting done.
REQ-025 Error rule: err_count increments when ok=0, or when ok=1 and instr_out != instruction.
REQ-026 ovf_count increments when ovf=1, independent of ok.
REQ-027 Counters SHALL be 5-bit and cannot exceed 16; no saturation logic is required.
REQ-028 ovf_count, err_count and signature SHALL hold their final values after DONE until the next accepted start.
REQ-029 start asserted while busy, or in DONE, SHALL be ignored; op changes while busy SHALL have no effect.
REQ-030 X/Z on ok or ovf SHALL be treated as 0 for counting; ok=X therefore counts as an error.
REQ-031 instruction, data0 and data1 SHALL remain stable between the edges that change them, with no glitches in IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force the following values, regardless of clk: state=IDLE, instruction=0, data0=0, data1=0, busy=0, done=0, ovf_count=0, err_count=0, signature=0.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; after release, no done pulse occurs until a new start is accepted.

Verification
REQ-034 The bench SHALL use a behavioural ALU stub: ok=1, instr_out=instruction, {out1,out0}=data0+data1 (4-bit), ovf=(data0+data1>3).
REQ-035 SETTLE=2, op=0x02, one start pulse -> busy for 49 cycles; done at cycle 49; ovf_count=6; err_count=0; signature=0x0.
REQ-036 Stub with ok forced 0 and op=0xF0 -> err_count=16; ovf_count=6.
REQ-037 Stub with instr_out=instruction^0x01 -> err_count=16; done latency unchanged.
REQ-038 start held high for the whole sweep -> exactly one sweep and one done pulse; a second sweep starts only from IDLE.
REQ-039 rst_n pulsed low at vector 7 -> all outputs zero at once; no done; a fresh start afterwards reproduces the REQ-035 results.
REQ-040 SETTLE=0 -> done 17 cycles after start; data0/data1 step every cycle in the order of REQ-022.

Source files
------------

// File: rtl/instr_sweeper.sv
// instr_sweeper: drives one instruction through all 16 two-bit operand pairs and
// tallies overflow responses, echo errors and an XOR signature of the results.
module instr_sweeper #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] op,
   output logic [7:0] instruction,
   output logic [1:0] data0,
   output logic [1:0] data1,
   input  logic       ok,
   input  logic       ovf,
   input  logic [7:0] instr_out,
   input  logic [1:0] out0,
   input  logic [1:0] out1,
   output logic       busy,
   output logic       done,
   output logic [4:0] ovf_count,
   output logic [4:0] err_count,
   output logic [3:0] signature
);
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   localparam logic [3:0] SET = 4'(SETTLE);
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d, vec_q, vec_d, sig_q, sig_d;
   logic [7:0] instr_q, instr_d;
   logic [4:0] ovf_q, ovf_d, err_q, err_d;
   logic       ok_v, ovf_v;
   // an unknown response must not count as valid or as overflow
   always_comb begin
      ok_v  = 1'b0;
      ovf_v = 1'b0;
      if (ok) ok_v = 1'b1;
      if (ovf) ovf_v = 1'b1;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      vec_d   = vec_q;
      instr_d = instr_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      sig_d   = sig_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = DRIVE;
            cnt_d   = 4'd0;
            vec_d   = 4'd0;
            instr_d = op;
            ovf_d   = 5'd0;
            err_d   = 5'd0;
            sig_d   = 4'd0;
         end
         DRIVE: begin
            state_d = (cnt_q == SET) ? SAMPLE : DRIVE;
            cnt_d   = cnt_q + 4'd1;
         end
         SAMPLE: begin
            ovf_d   = ovf_q + 5'(ovf_v);
            err_d   = err_q + 5'(!ok_v || instr_out != instr_q);
            sig_d   = sig_q ^ {out1, out0};
            vec_d   = vec_q + 4'd1;
            // the sample cycle already counts as one hold cycle of the next vector
            cnt_d   = 4'd1;
            state_d = (vec_q == 4'hf) ? DONE : ((SET == 4'd0) ? SAMPLE : DRIVE);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         vec_q   <= 4'd0;
         instr_q <= 8'd0;
         ovf_q   <= 5'd0;
         err_q   <= 5'd0;
         sig_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vec_q   <= vec_d;
         instr_q <= instr_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         sig_q   <= sig_d;
      end
   end
   assign instruction = instr_q;
   assign data0       = vec_q[3:2];
   assign data1       = vec_q[1:0];
   assign busy        = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done        = (state_q == DONE);
   assign ovf_count   = ovf_q;
   assign err_count   = err_q;
   assign signature   = sig_q;
endmodule
